comp_sort_ctrl: RTL and testbench



---
 rtl/comp_sort_pkg.sv | 20 ++
 rtl/comp.sv | 19 +
 rtl/comp_sort_ctrl.sv | 137 +++++++++++++
 tb/tb_comp_sort_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/comp_sort_pkg.sv
// Shared types and constants for the comparator-sharing bubble-sort controller.
package comp_sort_pkg;

    // Controller states: load/readback, one compare per cycle, exchange, completion pulse.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        SWAP    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int ENTRY_W = 4;   // width of one bank entry
    localparam int CNT_W   = 8;   // width of the swap counter

    // Saturating increment for the swap counter; sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/comp.sv
// 4-bit magnitude comparator shared by the sort controller.
module comp
    import comp_sort_pkg::*;
(
    input  logic [ENTRY_W-1:0] in_1,
    input  logic [ENTRY_W-1:0] in_2,
    output logic               great,
    output logic               equal,
    output logic               less
);

    // Exactly one of the three flags is high for any input pair.
    always_comb begin
        great = (in_1 >  in_2);
        equal = (in_1 == in_2);
        less  = (in_1 <  in_2);
    end

endmodule

// File: rtl/comp_sort_ctrl.sv
// Bubble-sorts an N-entry bank of 4-bit values in place using a single shared
// comparator, one comparison per cycle, with early exit on a swap-free pass.
module comp_sort_ctrl
    import comp_sort_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               start,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   swap_count
);

    // Bank is sized to the full address space so every address decodes to a
    // real register; the sort itself only ever touches entries 0..N-1.
    localparam int            DEPTH      = 1 << AW;
    localparam logic [AW-1:0] LIMIT_INIT = AW'(N - 1);

    state_t                          state, state_nxt;
    logic [DEPTH-1:0][ENTRY_W-1:0]   bank;
    logic [AW-1:0]                   idx, idx_p1, limit;
    logic                            swapped;

    logic [ENTRY_W-1:0]              cmp_a, cmp_b;
    logic                            great, equal, less;

    logic                            advance;      // leaving the current pair this cycle
    logic                            pass_end;     // current pair is the last of the pass
    logic                            swapped_eff;  // pass saw a swap, including this cycle's
    logic                            finish;       // sort terminates on this advance

    assign idx_p1  = idx + AW'(1);
    assign cmp_a   = bank[idx];
    assign cmp_b   = bank[idx_p1];
    assign rd_data = bank[rd_addr];

    comp u_comp (
        .in_1  (cmp_a),
        .in_2  (cmp_b),
        .great (great),
        .equal (equal),
        .less  (less)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: swap on great, otherwise step to the next pair or finish.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COMPARE;
            COMPARE: begin
                if (great)       state_nxt = SWAP;
                else if (finish) state_nxt = DONE;
            end
            SWAP:    state_nxt = finish ? DONE : COMPARE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and advance control; a swap in progress counts toward the pass's
    // swapped flag so a swap on the last pair of a pass still forces another pass.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        advance     = 1'b0;
        swapped_eff = swapped;
        case (state)
            COMPARE: begin
                busy    = 1'b1;
                advance = less | equal;
            end
            SWAP: begin
                busy        = 1'b1;
                advance     = 1'b1;
                swapped_eff = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
        pass_end = (idx_p1 >= limit);
        finish   = advance && pass_end && (!swapped_eff || (limit == AW'(1)));
    end

    // Bank, pass bookkeeping and swap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank       <= '0;
            idx        <= '0;
            limit      <= LIMIT_INIT;
            swapped    <= 1'b0;
            swap_count <= '0;
        end else begin
            if (state == IDLE) begin
                // Write lands on the same edge that samples start, so a
                // coincident write is part of the sort.
                if (wr_en) bank[wr_addr] <= wr_data;
                if (start) begin
                    swap_count <= '0;
                    idx        <= '0;
                    limit      <= LIMIT_INIT;
                    swapped    <= 1'b0;
                end
            end
            if (state == SWAP) begin
                bank[idx]    <= cmp_b;
                bank[idx_p1] <= cmp_a;
                swapped      <= 1'b1;
                swap_count   <= sat_inc(swap_count);
            end
            if (advance) begin
                if (!pass_end) begin
                    idx <= idx_p1;
                end else if (!finish) begin
                    // New pass: the largest remaining value has bubbled into place.
                    limit   <= limit - AW'(1);
                    idx     <= '0;
                    swapped <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_comp_sort_ctrl.sv
module tb_comp_sort_ctrl;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0]    wr_data = '0;
    logic          start = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [3:0]    rd_data;
    logic          busy;
    logic          done;
    logic [7:0]    swap_count;

    int n_cmp = 0;
    int n_err = 0;
    int mdl[N];
    int exp_c, exp_s;

    comp_sort_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Textbook bubble sort with early exit over the model contents.
    task automatic ref_sort();
        int a[N];
        int t;
        bit sw;
        a = mdl;
        exp_c = 0;
        exp_s = 0;
        for (int lim = N - 1; lim >= 1; lim--) begin
            sw = 1'b0;
            for (int i = 0; i < lim; i++) begin
                exp_c++;
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                    exp_s++;
                    sw = 1'b1;
                end
            end
            if (!sw) break;
        end
        mdl = a;
    endtask

    task automatic load(input int v[N]);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = 4'(v[i]);
            mdl[i]  = v[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_addr = AW'(i);
            #1;
            chk($sformatf("%s rd[%0d]", tag, i), 32'(rd_data), 32'(mdl[i]));
        end
    endtask

    // Start a sort (optionally with a coincident write), optionally poke
    // wr_en/start while busy, then check timing, count and final contents.
    task automatic run_sort(input string tag, input bit inject, input bit co_en,
                            input int co_addr, input int co_data, output int k);
        int cyc;
        bit got;
        if (co_en) mdl[co_addr] = co_data;
        ref_sort();
        @(negedge clk);
        start   = 1'b1;
        wr_en   = co_en;
        wr_addr = AW'(co_addr);
        wr_data = 4'(co_data);
        @(posedge clk);
        cyc = 0; got = 1'b0; k = 0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (done) begin
                got = 1'b1;
                k   = cyc + 1;
            end else begin
                chk({tag, " busy"}, 32'(busy), 32'd1);
                if (inject && cyc == 2) begin
                    start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 4'hF;
                end
                @(posedge clk);
                cyc++;
            end
        end
        chk({tag, " done seen"}, 32'(got), 32'd1);
        chk({tag, " done cycle"}, 32'(k), 32'(exp_c + exp_s + 1));
        chk({tag, " busy in done"}, 32'(busy), 32'd0);
        chk({tag, " swap_count"}, 32'(swap_count), 32'(exp_s));
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " swap hold"}, 32'(swap_count), 32'(exp_s));
        readback(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat[N];
        int k;

        // Reset state
        for (int i = 0; i < N; i++) mdl[i] = 0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset swap_count", 32'(swap_count), 32'd0);
        readback("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Already sorted
        pat = '{1, 2, 3, 4, 5, 6, 7, 8};
        load(pat);
        run_sort("sorted", 1'b0, 1'b0, 0, 0, k);
        chk("sorted cycle 8", 32'(k), 32'd8);
        chk("sorted swaps 0", 32'(swap_count), 32'd0);

        // Fully reversed
        pat = '{15, 14, 13, 12, 11, 10, 9, 8};
        load(pat);
        run_sort("reversed", 1'b0, 1'b0, 0, 0, k);
        chk("reversed cycle 57", 32'(k), 32'd57);
        chk("reversed swaps 28", 32'(swap_count), 32'd28);

        // Duplicates: equal pairs never swap
        pat = '{3, 3, 1, 3, 0, 15, 1, 3};
        load(pat);
        run_sort("dups", 1'b0, 1'b0, 0, 0, k);

        // wr_en/start during busy are ignored
        for (int i = 0; i < N; i++) pat[i] = int'($urandom_range(0, 14));
        load(pat);
        run_sort("busy_poke", 1'b1, 1'b0, 0, 0, k);

        // Coincident start and write in IDLE include the written value
        for (int i = 0; i < N; i++) pat[i] = int'($urandom_range(1, 15));
        load(pat);
        run_sort("co_write", 1'b0, 1'b1, 5, 0, k);

        // Random patterns
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < N; i++) pat[i] = int'($urandom_range(0, 15));
            load(pat);
            run_sort($sformatf("rand%0d", j), 1'b0, 1'b0, 0, 0, k);
        end

        // Reset in the middle of a reversed sort
        pat = '{15, 14, 13, 12, 11, 10, 9, 8};
        load(pat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) mdl[i] = 0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst swap_count", 32'(swap_count), 32'd0);
        readback("midrst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("midrst no done %0d", c), 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset done", 32'(done), 32'd0);

        // Fresh load and sort after the reset
        for (int i = 0; i < N; i++) pat[i] = int'($urandom_range(0, 15));
        load(pat);
        run_sort("after_rst", 1'b0, 1'b0, 0, 0, k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
